// File: rtl/seven_seg_scan_n_if.sv
// Display-side bundle for seven_seg_scan_n: value/control inputs towards the
// driver and the active-low pin outputs plus scan status back.
interface seven_seg_scan_n_if #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BRIGHT_W = 4
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   enable;
  logic [DIGITS-1:0]   blink;
  logic                lz_suppress;
  logic [BRIGHT_W-1:0] brightness;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic [IDX_W-1:0]    digit_idx;
  logic                frame_done;

  modport master (
    output digits, points, enable, blink, lz_suppress, brightness,
    input  seg, dp, an, digit_idx, frame_done
  );

  modport slave (
    input  digits, points, enable, blink, lz_suppress, brightness,
    output seg, dp, an, digit_idx, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_n.sv
// Multiplexed N-digit hex seven-segment driver with internal scan prescaler,
// frame-shadowed inputs, blink, leading-zero blanking, PWM brightness and anode gap.
module seven_seg_scan_n #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE_W = 12,
  parameter int unsigned BRIGHT_W   = 4,
  parameter int unsigned BLINK_W    = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  seven_seg_scan_n_if.slave bus
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NIB_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [PRESCALE_W-1:0]   pre;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      frame_cnt;
  logic                    phase;
  logic [NIB_W*DIGITS-1:0] sh_digits;
  logic [DIGITS-1:0]       sh_points;
  logic [DIGITS-1:0]       sh_enable;
  logic [DIGITS-1:0]       sh_blink;
  logic                    sh_lz;

  logic                    tick;
  logic                    frame_end;
  logic [NIB_W-1:0]        nibble;
  logic [DIGITS-1:0]       lz_mask;
  logic                    higher_zero;
  logic                    lit;
  logic                    suppress;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [DIGITS-1:0]       an_d;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [DIGITS-1:0]       an_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    frame_done_q;

  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick      = &pre;
  assign frame_end = tick && (idx == LAST_IDX);

  // Scan counters, blink phase and frame-boundary shadow capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      sh_digits <= '0;
      sh_points <= '0;
      sh_enable <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
    end else begin
      pre <= pre + PRESCALE_W'(1);
      if (tick) idx <= frame_end ? '0 : idx + IDX_W'(1);
      if (frame_end) begin
        sh_digits <= bus.digits;
        sh_points <= bus.points;
        sh_enable <= bus.enable;
        sh_blink  <= bus.blink;
        sh_lz     <= bus.lz_suppress;
        frame_cnt <= frame_cnt + BLINK_W'(1);
        if (&frame_cnt) phase <= ~phase;
      end
    end
  end

  // Next pin values for the digit in the current slot
  always_comb begin
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    an_d        = '1;
    lz_mask     = '0;
    higher_zero = 1'b1;
    nibble      = sh_digits[NIB_W*int'(idx) +: NIB_W];

    // lz_mask[i]: nibble i and every more significant nibble are zero
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (sh_digits[NIB_W*i +: NIB_W] == '0);
      lz_mask[i]  = higher_zero;
    end

    lit = sh_enable[idx] && !(sh_blink[idx] && phase) && (pre != '0) &&
          ((pre[PRESCALE_W-1 -: BRIGHT_W] < bus.brightness) || (&bus.brightness));
    suppress = (idx != '0) && sh_lz && lz_mask[idx];

    if (lit) begin
      an_d[idx] = 1'b0;
      dp_d      = ~sh_points[idx];
      if (!suppress) seg_d = decode_hex(nibble);
    end
  end

  // Registered pin outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      idx_q        <= idx;
      frame_done_q <= frame_end;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n: 4 digits, 16-cycle slots, 2-bit brightness.
module tb_seven_seg_scan_n;
  logic clk;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cur         = 0;
  int   frame_no    = 0;
  int   n;
  logic [3:0] blink_an0 [4];

  seven_seg_scan_n_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

  seven_seg_scan_n #(
    .DIGITS(4), .PRESCALE_W(4), .BRIGHT_W(2), .BLINK_W(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Move to the sample point showing slot s, prescaler p of the current frame
  task automatic goto_slot(input int s, input int p);
    int pos;
    pos = 16*s + p + 1;
    if (pos > cur) begin
      step(pos - cur);
      cur = pos;
    end
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!bus.frame_done && cycles < 200);
    if (!bus.frame_done) check_val("frame_timeout", 32'(0), 32'(1));
    cur = 0;
    frame_no++;
  endtask

  task automatic check_slot(input string tag, input int s, input int p,
                            input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
    goto_slot(s, p);
    check_val({tag, "_an"},  32'(bus.an),  32'(an_e));
    check_val({tag, "_seg"}, 32'(bus.seg), 32'(seg_e));
    check_val({tag, "_dp"},  32'(bus.dp),  32'(dp_e));
  endtask

  initial begin
    clk                = 1'b0;
    reset_n            = 1'b0;
    bus.digits         = 16'h3210;
    bus.points         = 4'b1000;
    bus.enable         = 4'hF;
    bus.blink          = 4'b0000;
    bus.lz_suppress    = 1'b0;
    bus.brightness     = 2'd3;
    // frames 7..10 have blink phase 1,0,0,1 -> digit 0 dark, lit, lit, dark
    blink_an0[0] = 4'hF; blink_an0[1] = 4'hE; blink_an0[2] = 4'hE; blink_an0[3] = 4'hF;

    step(3);
    check_val("rst_an",  32'(bus.an),         32'hF);
    check_val("rst_seg", 32'(bus.seg),        32'h7F);
    check_val("rst_dp",  32'(bus.dp),         32'h1);
    check_val("rst_idx", 32'(bus.digit_idx),  32'h0);
    check_val("rst_fd",  32'(bus.frame_done), 32'h0);
    reset_n = 1'b1;
    cur     = 0;

    // frame 0: shadows still zero
    check_slot("f0_s0", 0, 4, 4'hF, 7'h7F, 1'b1);
    check_slot("f0_s2", 2, 8, 4'hF, 7'h7F, 1'b1);
    wait_frame(n);

    // frame 1: 3210 with dp on digit 3
    check_slot("f1_s0", 0, 8, 4'hE, 7'h40, 1'b1);
    check_val("f1_idx0", 32'(bus.digit_idx), 32'd0);
    check_slot("f1_gap", 1, 0, 4'hF, 7'h7F, 1'b1);
    check_slot("f1_s1", 1, 8, 4'hD, 7'h79, 1'b1);
    check_val("f1_idx1", 32'(bus.digit_idx), 32'd1);
    check_slot("f1_s2", 2, 8, 4'hB, 7'h24, 1'b1);
    check_slot("f1_s3", 3, 8, 4'h7, 7'h30, 1'b0);
    check_val("f1_idx3", 32'(bus.digit_idx), 32'd3);
    wait_frame(n);
    wait_frame(n);
    check_val("frame_period", 32'(n), 32'd64);
    goto_slot(0, 0);
    check_val("frame_done_pulse", 32'(bus.frame_done), 32'd0);

    // brightness 1: lit only for prescaler 1..3
    bus.brightness = 2'd1;
    check_slot("b1_p0",  1, 0,  4'hF, 7'h7F, 1'b1);
    check_slot("b1_p1",  1, 1,  4'hD, 7'h79, 1'b1);
    check_slot("b1_p3",  1, 3,  4'hD, 7'h79, 1'b1);
    check_slot("b1_p4",  1, 4,  4'hF, 7'h7F, 1'b1);
    check_slot("b1_p15", 1, 15, 4'hF, 7'h7F, 1'b1);
    check_slot("b1_s2",  2, 2,  4'hB, 7'h24, 1'b1);
    bus.brightness = 2'd0;
    check_slot("b0_p3",  2, 3,  4'hF, 7'h7F, 1'b1);
    check_slot("b0_s3",  3, 8,  4'hF, 7'h7F, 1'b1);
    bus.brightness = 2'd3;

    // leading-zero suppression on 00A0
    wait_frame(n);
    bus.digits      = 16'h00A0;
    bus.lz_suppress = 1'b1;
    wait_frame(n);
    check_slot("lz_s0", 0, 8, 4'hE, 7'h40, 1'b1);
    check_slot("lz_s1", 1, 8, 4'hD, 7'h08, 1'b1);
    check_slot("lz_s2", 2, 8, 4'hB, 7'h7F, 1'b1);
    check_slot("lz_s3", 3, 8, 4'h7, 7'h7F, 1'b0);

    // blink on digit 0 only
    wait_frame(n);
    bus.digits      = 16'h3210;
    bus.lz_suppress = 1'b0;
    bus.blink       = 4'b0001;
    wait_frame(n);
    for (int f = 0; f < 4; f++) begin
      goto_slot(0, 8);
      check_val("blink_d0_an", 32'(bus.an), 32'(blink_an0[f]));
      check_slot("blink_d1", 1, 8, 4'hD, 7'h79, 1'b1);
      wait_frame(n);
    end
    bus.blink = 4'b0000;

    // mid-frame digit change must not tear the frame
    check_slot("tear_s1", 1, 8, 4'hD, 7'h79, 1'b1);
    bus.digits = 16'h7654;
    check_slot("tear_s2", 2, 8, 4'hB, 7'h24, 1'b1);
    check_slot("tear_s3", 3, 8, 4'h7, 7'h30, 1'b0);
    wait_frame(n);
    check_slot("new_s0", 0, 8, 4'hE, 7'h19, 1'b1);
    check_slot("new_s1", 1, 8, 4'hD, 7'h12, 1'b1);
    check_slot("new_s2", 2, 8, 4'hB, 7'h02, 1'b1);
    check_slot("new_s3", 3, 8, 4'h7, 7'h78, 1'b0);

    // asynchronous reset between clock edges
    wait_frame(n);
    check_slot("pre_rst", 1, 5, 4'hD, 7'h12, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_an",  32'(bus.an),        32'hF);
    check_val("arst_seg", 32'(bus.seg),       32'h7F);
    check_val("arst_dp",  32'(bus.dp),        32'h1);
    check_val("arst_idx", 32'(bus.digit_idx), 32'h0);
    step(3);
    reset_n = 1'b1;
    cur     = 0;
    check_slot("rel_dark", 0, 4, 4'hF, 7'h7F, 1'b1);
    check_val("rel_idx", 32'(bus.digit_idx), 32'd0);
    wait_frame(n);
    check_val("rel_first_frame", 32'(n), 32'd59);
    check_slot("rel_s0", 0, 8, 4'hE, 7'h19, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
